logic_cmd_sequencer: RTL and testbench
======================================

Name: logic_cmd_sequencer

Overview:
Initiator for the 4-bit logic unit. Accepts logic commands {opcode, a, b} over a valid/ready stream and buffers them in a small FIFO. Issues one command at a time to an external combinational logic unit, captures its result, and returns it over a valid/ready response stream. Sits between the control path and the logic unit datapath.

Parameters:
D_S, 4, operand/result width
D_W, 2, opcode width
FIFO_DEPTH, 4, command FIFO entries; power of 2, >= 2

Ports:
clk_in  input  1  clock, rising edge
rst_in  input  1  asynchronous reset, active-high
cmd_valid_in  input  1  command valid
cmd_ready_out  output  1  command ready
cmd_opcode_in  input  D_W  opcode: 00 OR, 01 XOR, 10 AND, 11 NOT(a)
cmd_a_in  input  D_S  operand a
cmd_b_in  input  D_S  operand b
lu_opcode_out  output  D_W  opcode to logic unit
lu_a_out  output  D_S  operand a to logic unit
lu_b_out  output  D_S  operand b to logic unit
lu_result_in  input  D_S  logic unit result (combinational from lu_* outputs)
rsp_valid_out  output  1  response valid
rsp_ready_in  input  1  response ready
rsp_data_out  output  D_S  captured result
rsp_opcode_out  output  D_W  opcode of the response
count_out  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy
err_out  output  1  sticky self-check error (see Optional Feature)

Behaviour:
- Reset (async, rst_in=1): FIFO flushed; state IDLE; all registered outputs 0 (lu_*, rsp_*, count_out, err_out). cmd_ready_out = 0 while rst_in high.
- cmd_ready_out = !full && !rst_in, combinational from registered occupancy. A pop in the same cycle does not raise ready.
- Push on cmd_valid_in && cmd_ready_out. Push and pop on the same edge leave count_out unchanged. The FIFO is strictly in-order; pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: if the FIFO is non-empty, pop the head into the lu_* registers and go to ISSUE. Otherwise stay.
  - ISSUE: lu_* outputs are stable for exactly this cycle. At the closing edge, register lu_result_in into rsp_data_out and the opcode into rsp_opcode_out, set rsp_valid_out=1, and go to RESP.
  - RESP: rsp_valid_out, rsp_data_out and rsp_opcode_out are held stable until rsp_ready_in=1. On handshake: if the FIFO is non-empty, pop the next command and go to ISSUE (rsp_valid_out drops for that one cycle). Otherwise clear rsp_valid_out and go to IDLE.
- lu_* outputs hold their last issued values outside ISSUE. They are not cleared.
- Latency: a command accepted at edge E0 into an empty FIFO with state IDLE is issued after E1. rsp_valid_out rises after E2.
- Throughput: 1 response per 2 cycles with rsp_ready_in held high.
- Capacity: FIFO_DEPTH queued commands plus 1 in flight or in response.
- Widths: the sequencer does no arithmetic; data passes through unmodified at D_S bits.
- Reset mid-operation: the pending response and all queued commands are discarded. No response is produced after reset release.

Optional Feature:
Macro LOGIC_SEQ_SELFCHECK_EN.
- Defined: an internal reference model computes the expected result from the issued opcode and operands (OR a|b, XOR a^b, AND a&b, NOT ~a). At ISSUE capture, a mismatch with lu_result_in sets err_out=1. err_out stays set until rst_in.
- Undefined: the model is not compiled and err_out is tied to 0.

Test Plan:
1. Reset check: hold rst_in=1 -> all outputs 0 and cmd_ready_out=0. Release rst_in -> cmd_ready_out=1, count_out=0, rsp_valid_out=0.
2. Single XOR, a=4'hA, b=4'h6, accepted at E0 -> after E1, lu_opcode_out=01, lu_a_out=A, lu_b_out=6. After E2, rsp_valid_out=1, rsp_data_out=4'hC, rsp_opcode_out=01.
3. Fill with rsp_ready_in=0: drive cmd_valid_in continuously with 6 commands -> exactly 5 accepted (1 in RESP, 4 queued), count_out=4, cmd_ready_out=0. The response stays stable.
4. Drain: raise rsp_ready_in with queue {OR 3|5, AND C&A, NOT a=3, XOR F^F} -> in-order responses 4'h7, 4'h8, 4'hC, 4'h0. rsp_valid_out toggles 1/0 (2-cycle spacing). count_out reaches 0, then state IDLE.
5. Reset mid-operation: with 3 commands queued and rsp_valid_out=1, pulse rst_in asynchronously -> rsp_valid_out=0 and count_out=0 immediately. No response appears for 10 cycles after release.
6. With LOGIC_SEQ_SELFCHECK_EN, force lu_result_in=4'h0 during an OR 1|2 issue -> err_out=1 after capture and held until reset. Without the macro, the same stimulus -> err_out=0.

Source files
------------

// File: rtl/logic_cmd_sequencer.sv
// Command sequencer for the 4-bit logic unit: FIFO-buffered commands, one issue at a time,
// captured result returned on a valid/ready stream. Optional self-check: LOGIC_SEQ_SELFCHECK_EN.
//
// state | meaning
// IDLE  | no command in flight; pop the FIFO head when available
// ISSUE | lu_* driven for exactly one cycle; result captured at the closing edge
// RESP  | response held on rsp_* until rsp_ready_in
module logic_cmd_sequencer #(
    parameter int D_S        = 4,
    parameter int D_W        = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          cmd_valid_in,
    output logic                          cmd_ready_out,
    input  logic [D_W-1:0]                cmd_opcode_in,
    input  logic [D_S-1:0]                cmd_a_in,
    input  logic [D_S-1:0]                cmd_b_in,
    output logic [D_W-1:0]                lu_opcode_out,
    output logic [D_S-1:0]                lu_a_out,
    output logic [D_S-1:0]                lu_b_out,
    input  logic [D_S-1:0]                lu_result_in,
    output logic                          rsp_valid_out,
    input  logic                          rsp_ready_in,
    output logic [D_S-1:0]                rsp_data_out,
    output logic [D_W-1:0]                rsp_opcode_out,
    output logic [$clog2(FIFO_DEPTH):0]   count_out,
    output logic                          err_out
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = D_W + 2 * D_S;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t        state_q;
    state_t        state_d;
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          empty;

    assign empty         = (count_out == '0);
    assign cmd_ready_out = (count_out != FULL_CNT) && !rst_in;
    assign push          = cmd_valid_in && cmd_ready_out;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = RESP;
            RESP: begin
                if (rsp_ready_in) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Pointers wrap naturally since FIFO_DEPTH is a power of two.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_out <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count_out <= count_out + 1'b1;
            else if (pop && !push) count_out <= count_out - 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) mem[wr_ptr] <= {cmd_opcode_in, cmd_a_in, cmd_b_in};
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            lu_opcode_out  <= '0;
            lu_a_out       <= '0;
            lu_b_out       <= '0;
            rsp_valid_out  <= 1'b0;
            rsp_data_out   <= '0;
            rsp_opcode_out <= '0;
        end else begin
            if (pop) {lu_opcode_out, lu_a_out, lu_b_out} <= mem[rd_ptr];
            if (state_q == ISSUE) begin
                rsp_valid_out  <= 1'b1;
                rsp_data_out   <= lu_result_in;
                rsp_opcode_out <= lu_opcode_out;
            end else if (state_q == RESP && rsp_ready_in) begin
                rsp_valid_out  <= 1'b0;
            end
        end
    end

`ifdef LOGIC_SEQ_SELFCHECK_EN
    logic [D_S-1:0] model_result;

    always_comb begin
        model_result = '0;
        case (lu_opcode_out)
            D_W'(0): model_result = lu_a_out | lu_b_out;
            D_W'(1): model_result = lu_a_out ^ lu_b_out;
            D_W'(2): model_result = lu_a_out & lu_b_out;
            default: model_result = ~lu_a_out;
        endcase
    end

    // Sticky until reset so a single corrupted capture is never lost.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)                                             err_out <= 1'b0;
        else if (state_q == ISSUE && lu_result_in != model_result) err_out <= 1'b1;
    end
`else
    assign err_out = 1'b0;
`endif

endmodule

// File: tb/tb_logic_cmd_sequencer.sv
// Self-checking bench for logic_cmd_sequencer: directed scenarios plus a randomized phase
// scored against an in-order queue of expected {opcode, result} responses.
module tb_logic_cmd_sequencer;
    localparam int D_S = 4;
    localparam int D_W = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

`ifdef LOGIC_SEQ_SELFCHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic           clk_in = 1'b0;
    logic           rst_in;
    logic           cmd_valid_in;
    logic           cmd_ready_out;
    logic [D_W-1:0] cmd_opcode_in;
    logic [D_S-1:0] cmd_a_in;
    logic [D_S-1:0] cmd_b_in;
    logic [D_W-1:0] lu_opcode_out;
    logic [D_S-1:0] lu_a_out;
    logic [D_S-1:0] lu_b_out;
    logic [D_S-1:0] lu_result_in;
    logic           rsp_valid_out;
    logic           rsp_ready_in;
    logic [D_S-1:0] rsp_data_out;
    logic [D_W-1:0] rsp_opcode_out;
    logic [CW-1:0]  count_out;
    logic           err_out;

    int   total = 0;
    int   bad   = 0;
    logic lu_stuck = 1'b0;

    typedef struct {
        logic [D_W-1:0] op;
        logic [D_S-1:0] res;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;

    always #5 clk_in = ~clk_in;

    logic_cmd_sequencer #(.D_S(D_S), .D_W(D_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
        .cmd_opcode_in(cmd_opcode_in), .cmd_a_in(cmd_a_in), .cmd_b_in(cmd_b_in),
        .lu_opcode_out(lu_opcode_out), .lu_a_out(lu_a_out), .lu_b_out(lu_b_out),
        .lu_result_in(lu_result_in),
        .rsp_valid_out(rsp_valid_out), .rsp_ready_in(rsp_ready_in),
        .rsp_data_out(rsp_data_out), .rsp_opcode_out(rsp_opcode_out),
        .count_out(count_out), .err_out(err_out)
    );

    function automatic logic [D_S-1:0] ref_op(input logic [D_W-1:0] op, input logic [D_S-1:0] a,
                                              input logic [D_S-1:0] b);
        case (op)
            2'd0:    return a | b;
            2'd1:    return a ^ b;
            2'd2:    return a & b;
            default: return ~a;
        endcase
    endfunction

    // External logic unit; lu_stuck models a broken unit that outputs zero.
    assign lu_result_in = lu_stuck ? '0 : ref_op(lu_opcode_out, lu_a_out, lu_b_out);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: commands accepted become expected responses, in order.
    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            q.delete();
        end else begin
            if (cmd_valid_in && cmd_ready_out)
                q.push_back('{op: cmd_opcode_in,
                              res: lu_stuck ? 4'h0 : ref_op(cmd_opcode_in, cmd_a_in, cmd_b_in)});
            if (rsp_valid_out && rsp_ready_in) begin
                check("rsp_expected_pending", 32'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    mon_e = q.pop_front();
                    check("rsp_data", rsp_data_out, mon_e.res);
                    check("rsp_opcode", rsp_opcode_out, mon_e.op);
                end
            end
        end
    end

    task automatic push_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        bit ok;
        int n;
        ok = 1'b0;
        n  = 0;
        @(posedge clk_in); #1;
        cmd_valid_in = 1'b1; cmd_opcode_in = op; cmd_a_in = a; cmd_b_in = b;
        while (!ok && n < 50) begin
            @(negedge clk_in);
            ok = cmd_ready_out;
            @(posedge clk_in); #1;
            n++;
        end
        cmd_valid_in = 1'b0;
        check("push_accepted", 32'(ok), 1);
    endtask

    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        while (rsp_valid_out !== 1'b1 && n < 20) begin
            @(negedge clk_in);
            n++;
        end
        check({tag, "_rsp_seen"}, rsp_valid_out, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    logic [1:0] c_op [6];
    logic [3:0] c_a  [6];
    logic [3:0] c_b  [6];
    logic [3:0] drain_exp [5];
    int acc;
    int unstable;
    bit took;

    initial begin
        c_op = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd1, 2'd0};
        c_a  = '{4'h5, 4'h3, 4'hC, 4'h3, 4'hF, 4'h1};
        c_b  = '{4'h9, 4'h5, 4'hA, 4'h0, 4'hF, 4'h1};
        for (int i = 0; i < 5; i++) drain_exp[i] = ref_op(c_op[i], c_a[i], c_b[i]);

        rst_in = 1'b1; cmd_valid_in = 1'b0; cmd_opcode_in = '0; cmd_a_in = '0; cmd_b_in = '0;
        rsp_ready_in = 1'b0;

        // 1: reset state
        repeat (3) @(negedge clk_in);
        check("rst_ready", cmd_ready_out, 0);
        check("rst_rsp_valid", rsp_valid_out, 0);
        check("rst_rsp_data", rsp_data_out, 0);
        check("rst_rsp_opcode", rsp_opcode_out, 0);
        check("rst_count", count_out, 0);
        check("rst_err", err_out, 0);
        check("rst_lu", {lu_opcode_out, lu_a_out, lu_b_out}, 0);
        @(posedge clk_in); #1 rst_in = 1'b0;
        @(negedge clk_in);
        check("rel_ready", cmd_ready_out, 1);
        check("rel_count", count_out, 0);
        check("rel_rsp_valid", rsp_valid_out, 0);

        // 2: single XOR A^6, latency E0 -> issue after E1 -> response after E2
        @(posedge clk_in); #1;
        cmd_valid_in = 1'b1; cmd_opcode_in = 2'b01; cmd_a_in = 4'hA; cmd_b_in = 4'h6;
        @(posedge clk_in); #1 cmd_valid_in = 1'b0;
        @(negedge clk_in);
        check("lat_e0_count", count_out, 1);
        check("lat_e0_rsp_valid", rsp_valid_out, 0);
        @(negedge clk_in);
        check("lat_e1_lu", {lu_opcode_out, lu_a_out, lu_b_out}, {2'b01, 4'hA, 4'h6});
        check("lat_e1_rsp_valid", rsp_valid_out, 0);
        @(negedge clk_in);
        check("lat_e2_rsp_valid", rsp_valid_out, 1);
        check("lat_e2_rsp_data", rsp_data_out, 4'hC);
        check("lat_e2_rsp_opcode", rsp_opcode_out, 2'b01);
        check("lat_lu_hold", {lu_opcode_out, lu_a_out, lu_b_out}, {2'b01, 4'hA, 4'h6});
        @(posedge clk_in); #1 rsp_ready_in = 1'b1;
        @(posedge clk_in); #1 rsp_ready_in = 1'b0;
        @(negedge clk_in);
        check("ack_rsp_valid", rsp_valid_out, 0);

        // 3: fill with rsp_ready low, six commands offered back to back
        @(posedge clk_in); #1;
        acc = 0; unstable = 0;
        cmd_valid_in = 1'b1; cmd_opcode_in = c_op[0]; cmd_a_in = c_a[0]; cmd_b_in = c_b[0];
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(negedge clk_in);
            took = cmd_ready_out;
            if (rsp_valid_out && (rsp_data_out !== drain_exp[0] || rsp_opcode_out !== c_op[0]))
                unstable++;
            @(posedge clk_in); #1;
            if (took) begin
                acc++;
                if (acc < 6) begin
                    cmd_opcode_in = c_op[acc]; cmd_a_in = c_a[acc]; cmd_b_in = c_b[acc];
                end
            end
        end
        cmd_valid_in = 1'b0;
        @(negedge clk_in);
        check("fill_accepted", acc, 5);
        check("fill_count", count_out, 4);
        check("fill_ready", cmd_ready_out, 0);
        check("fill_rsp_valid", rsp_valid_out, 1);
        check("fill_rsp_data", rsp_data_out, drain_exp[0]);
        check("fill_rsp_stable", unstable, 0);

        // 4: drain; responses every other cycle, one queued command popped per response
        rsp_ready_in = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) @(negedge clk_in);
            check($sformatf("drain_valid_%0d", k), rsp_valid_out, 32'((k % 2 == 0) && (k <= 8)));
            if (k % 2 == 0 && k <= 8)
                check($sformatf("drain_data_%0d", k), rsp_data_out, drain_exp[k/2]);
            check($sformatf("drain_count_%0d", k), count_out,
                  32'((4 - (k + 1) / 2) < 0 ? 0 : (4 - (k + 1) / 2)));
        end
        rsp_ready_in = 1'b0;

        // 5: asynchronous reset with a held response and three queued commands
        for (int i = 0; i < 4; i++)
            push_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        wait_rsp("midrst");
        @(negedge clk_in);
        check("midrst_count_before", count_out, 3);
        #2 rst_in = 1'b1;
        #1;
        check("midrst_rsp_valid", rsp_valid_out, 0);
        check("midrst_count", count_out, 0);
        check("midrst_ready", cmd_ready_out, 0);
        #1 rst_in = 1'b0;
        rsp_ready_in = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_in);
            check($sformatf("postrst_quiet_%0d", k), {rsp_valid_out, count_out}, 0);
        end

        // 6: broken logic unit during an OR 1|2 issue
        lu_stuck = 1'b1;
        push_cmd(2'b00, 4'h1, 4'h2);
        wait_rsp("stuck");
        check("stuck_rsp_data", rsp_data_out, 4'h0);
        check("stuck_err", err_out, EXP_ERR);
        lu_stuck = 1'b0;
        push_cmd(2'b10, 4'hF, 4'h3);
        wait_rsp("good");
        check("good_rsp_data", rsp_data_out, 4'h3);
        check("err_sticky", err_out, EXP_ERR);
        @(posedge clk_in); #1 rst_in = 1'b1;
        #1 check("err_cleared", err_out, 0);
        @(posedge clk_in); #1 rst_in = 1'b0;

        // 7: randomized traffic scored by the response queue
        for (int cyc = 0; cyc < 400; cyc++) begin
            cmd_valid_in  = 1'($urandom_range(0, 1));
            cmd_opcode_in = 2'($urandom_range(0, 3));
            cmd_a_in      = 4'($urandom_range(0, 15));
            cmd_b_in      = 4'($urandom_range(0, 15));
            rsp_ready_in  = ($urandom_range(0, 3) != 0);
            @(negedge clk_in);
            check("rand_ready_vs_count", cmd_ready_out, 32'(count_out < CW'(FIFO_DEPTH)));
            check("rand_count_bound", 32'(count_out <= CW'(FIFO_DEPTH)), 1);
            @(posedge clk_in); #1;
        end
        cmd_valid_in = 1'b0;
        rsp_ready_in = 1'b1;
        repeat (20) @(negedge clk_in);
        check("final_queue_empty", q.size(), 0);
        check("final_count", count_out, 0);
        check("final_rsp_valid", rsp_valid_out, 0);
        check("final_err", err_out, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
